// File: rtl/trace_checker.sv
// trace_checker: golden-trace ROM reader and commit-stream checker; define TRACE_CHECK_WB_EN to also compare write-back fields.
module trace_checker #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int MAX_RECORDS = 2049,
  parameter int AW = 12
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          commit_valid,
  output logic          commit_ready,
  input  logic [31:0]   commit_pc,
  input  logic [31:0]   commit_inst,
  input  logic          commit_wen,
  input  logic [4:0]    commit_waddr,
  input  logic [31:0]   commit_wdata,
  output logic          gold_ren,
  output logic [AW-1:0] gold_addr,
  input  logic [101:0]  gold_rdata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [AW-1:0] mismatch_index,
  output logic [2:0]    mismatch_field,
  output logic [AW:0]   checked_count
);
  typedef enum logic [1:0] {FETCH0, RUN, FAIL, PASS} state_t;
  localparam logic [AW:0] MAX_C = MAX_RECORDS[AW:0];
  state_t state, state_n;
  logic [101:0] buf_q [2];
  logic [101:0] head;
  logic wr_ptr, rd_ptr, inflight, active, push, accept, issue;
  logic pc_bad, inst_bad, wb_bad, bad, last;
  logic [1:0] occ, lvl;
  logic [AW:0] fetched;
  logic [2:0] field;
  assign head = buf_q[rd_ptr];
  assign lvl = occ + {1'b0, inflight};
  assign active = state == FETCH0 || state == RUN;
  assign commit_ready = !reset && state == RUN && occ != 2'd0;
  assign accept = commit_valid && commit_ready;
  assign push = inflight && active;
  // A same-cycle pop frees a slot, which keeps one commit per cycle sustainable
  assign issue = !reset && active && fetched < MAX_C && (lvl < 2'd2 || (accept && lvl == 2'd2));
  assign gold_ren = issue;
  assign gold_addr = fetched[AW-1:0];
  assign done = state == FAIL || state == PASS;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign last = checked_count == MAX_C - 1'b1;
  assign pc_bad = (commit_pc - BASE_ADDR) != head[101:70];
  assign inst_bad = commit_inst != head[69:38];
`ifdef TRACE_CHECK_WB_EN
  assign wb_bad = commit_wen != head[37] ||
                  (commit_wen && head[37] && (commit_waddr != head[36:32] || commit_wdata != head[31:0]));
`else
  logic unused_wb;
  assign unused_wb = ^{commit_wen, commit_waddr, commit_wdata, head[37:0]};
  assign wb_bad = 1'b0;
`endif
  assign field = {wb_bad, inst_bad, pc_bad};
  assign bad = |field;
  always_comb begin
    state_n = state;
    state_n = (state == FETCH0 && inflight) ? RUN :
              accept ? (bad ? FAIL : (last ? PASS : RUN)) : state;
  end
  always_ff @(posedge clk_in) begin
    if (push) buf_q[wr_ptr] <= gold_rdata;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= FETCH0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
      inflight <= 1'b0;
      fetched <= '0;
      checked_count <= '0;
      mismatch_index <= '0;
      mismatch_field <= 3'd0;
    end else begin
      state <= state_n;
      inflight <= issue;
      occ <= occ + {1'b0, push} - {1'b0, accept};
      if (issue) fetched <= fetched + 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (accept) begin
        rd_ptr <= ~rd_ptr;
        checked_count <= checked_count + 1'b1;
        if (bad) begin
          mismatch_index <= checked_count[AW-1:0];
          mismatch_field <= field;
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: scoreboard bench for trace_checker against a golden ROM model.
module tb_trace_checker;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int N = 2049;
  typedef struct {
    logic        p;
    logic        f;
    logic [31:0] idx;
    logic [31:0] fld;
    logic [31:0] cnt;
  } exp_t;
  logic clk_in = 0, reset = 1, commit_valid = 0, commit_ready, commit_wen = 0;
  logic [31:0] commit_pc = 0, commit_inst = 0, commit_wdata = 0;
  logic [4:0] commit_waddr = 0;
  logic gold_ren, done, pass, fail;
  logic [11:0] gold_addr, mismatch_index;
  logic [101:0] gold_rdata = 0;
  logic [2:0] mismatch_field;
  logic [12:0] checked_count;
  logic [101:0] rom [0:4095];
  exp_t q[$];
  int tests = 0, fails = 0, bound_errs = 0;
  bit seen = 0;
  trace_checker dut (
    .clk_in(clk_in), .reset(reset), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_wen(commit_wen),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .gold_ren(gold_ren),
    .gold_addr(gold_addr), .gold_rdata(gold_rdata), .done(done), .pass(pass), .fail(fail),
    .mismatch_index(mismatch_index), .mismatch_field(mismatch_field), .checked_count(checked_count)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (gold_ren) gold_rdata <= rom[gold_addr];
  function automatic logic [101:0] rec_of(input int i);
    logic [31:0] pc, ins, wd;
    pc = i * 4;
    ins = 32'h0000_0013 ^ (i << 7) ^ (i * 32'h0001_0000);
    wd = (i == 7) ? 32'h1 : i * 7 + 3;
    return {pc, ins, i[0], i[4:0], wd};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_in) begin
    exp_t e;
    if (reset) seen = 0;
    else if (done && !seen) begin
      seen = 1;
      if (q.size() == 0) chk("sb_unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_pass", pass, e.p);
        chk("sb_fail", fail, e.f);
        chk("sb_index", mismatch_index, e.idx);
        chk("sb_field", mismatch_field, e.fld);
        chk("sb_count", checked_count, e.cnt);
      end
    end
  end
  task automatic expect_pass();
    q.push_back('{1'b1, 1'b0, 0, 0, N});
  endtask
  task automatic expect_fail(input int idx, input int fld);
    q.push_back('{1'b0, 1'b1, idx, fld, idx + 1});
  endtask
  task automatic drive(input int k, input int kind);
    logic [101:0] r;
    r = rec_of(k);
    commit_pc = BASE + r[101:70] + ((kind == 1) ? 32'd4 : 32'd0);
    commit_inst = r[69:38];
    commit_wen = r[37];
    commit_waddr = r[36:32];
    commit_wdata = (kind == 2) ? 32'h2 : r[31:0];
  endtask
  task automatic do_reset();
    commit_valid = 0;
    reset = 1;
    repeat (2) @(negedge clk_in);
    reset = 0;
  endtask
  task automatic run(input int bad_idx, input int kind, input int gap, input int stop_at);
    int k = 0, cyc = 0;
    bit v;
    while (!done && k < stop_at && cyc < 20000) begin
      @(negedge clk_in);
      cyc++;
      if (done) break;
      if (int'(gold_addr) > int'(checked_count) + 2) bound_errs++;
      v = (gap == 0) || (cyc % 3 == 1);
      drive(k, (k == bad_idx) ? kind : 0);
      commit_valid = v;
      if (v && commit_ready) k++;
    end
    if (!done && k < stop_at) chk("run_timeout", 0, 1);
    @(negedge clk_in);
    commit_valid = 0;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = rec_of(i);
    repeat (2) @(negedge clk_in);
    chk("rst_ready", commit_ready, 0);
    chk("rst_ren", gold_ren, 0);
    chk("rst_done", {done, pass, fail}, 0);
    chk("rst_addr", gold_addr, 0);
    chk("rst_index", mismatch_index, 0);
    chk("rst_field", mismatch_field, 0);
    chk("rst_count", checked_count, 0);
    reset = 0;
    #1;
    chk("first_ren", gold_ren, 1);
    chk("first_addr", gold_addr, 0);
    @(negedge clk_in);
    chk("ready_c1", commit_ready, 0);
    chk("addr_c1", gold_addr, 1);
    @(negedge clk_in);
    chk("ready_c2", commit_ready, 1);
    expect_pass();
    run(-1, 0, 0, 1 << 30);
    chk("clean_ready_after", commit_ready, 0);
    chk("clean_done", done, 1);
    do_reset();
    expect_fail(5, 1);
    run(5, 1, 0, 1 << 30);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      commit_valid = 1;
      commit_pc = $urandom;
      commit_inst = $urandom;
    end
    @(negedge clk_in);
    commit_valid = 0;
    chk("frz_index", mismatch_index, 5);
    chk("frz_field", mismatch_field, 1);
    chk("frz_count", checked_count, 6);
    chk("frz_ren", gold_ren, 0);
    chk("frz_flags", {done, pass, fail}, 3'b101);
    do_reset();
`ifdef TRACE_CHECK_WB_EN
    expect_fail(7, 4);
`else
    expect_pass();
`endif
    run(7, 2, 0, 1 << 30);
    do_reset();
    expect_pass();
    bound_errs = 0;
    run(-1, 0, 1, 1 << 30);
    chk("gap_addr_bound", bound_errs, 0);
    do_reset();
    run(-1, 0, 0, 100);
    chk("mid_count", checked_count, 100);
    reset = 1;
    @(negedge clk_in);
    chk("mid_rst_addr", gold_addr, 0);
    chk("mid_rst_count", checked_count, 0);
    chk("mid_rst_ready", commit_ready, 0);
    reset = 0;
    expect_pass();
    run(-1, 0, 0, 1 << 30);
    repeat (2) @(negedge clk_in);
    chk("sb_leftover", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
